// File: rtl/shift_cmd_fifo.sv
// shift_cmd_fifo
//   Command buffer in front of the 4-bit left/right shift register stage. Producer commands
//   {direction, data} are accepted over a valid/ready handshake and held in a small synchronous
//   FIFO. The oldest command is presented first-word-fall-through to the shifter.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   in_valid/in_ready      producer handshake; in_ready = !full
//   in_lr_bar, in_data     command direction (1 = left) and data word
//   out_valid/out_ready    consumer handshake; out_valid = !empty
//   out_lr_bar, out_data   head command, forced to 0 while empty
//   count, full, empty     occupancy status, all from registered state
//   ovf                    sticky "producer stalled against full FIFO" flag, cleared by rst
//                          (present only when SHIFT_CMD_FIFO_OVF_EN is defined)
//
// Parameters: DATA_W data width, DEPTH entries (power of two, >= 2), ADDR_W = log2(DEPTH).
module shift_cmd_fifo #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_lr_bar,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_lr_bar,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
`ifdef SHIFT_CMD_FIFO_OVF_EN
  output logic              ovf,
`endif
  output logic              empty
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  // Each entry keeps the direction bit alongside its data word: {lr_bar, data}.
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push, pop;

  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  // in_ready deliberately ignores out_ready: no push into a full FIFO even on a same-cycle pop.
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_lr_bar, in_data};
      // DEPTH is a power of two, so natural pointer overflow is the modulo-DEPTH wrap.
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers and count clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out_lr_bar = 1'b0;
    out_data   = '0;
    if (!empty) begin
      {out_lr_bar, out_data} = mem_q[rd_ptr_q];
    end
  end

`ifdef SHIFT_CMD_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q || (in_valid && full);
  assign ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Testbench for shift_cmd_fifo: directed test-plan sequences followed by randomized traffic,
// all checked each cycle against a queue-based reference model of the command buffer.
module tb_shift_cmd_fifo;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_lr_bar;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_lr_bar;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
`ifdef SHIFT_CMD_FIFO_OVF_EN
  logic              ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {lr_bar, data}, head at index 0.
  logic [DATA_W:0] model_q[$];
  logic            ovf_m;

  always #5 clk = ~clk;

  shift_cmd_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_lr_bar (in_lr_bar),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_lr_bar(out_lr_bar),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
`ifdef SHIFT_CMD_FIFO_OVF_EN
    .ovf       (ovf),
`endif
    .empty     (empty)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int unsigned sz;
    logic [DATA_W:0] head;
    sz   = model_q.size();
    head = (sz != 0) ? model_q[0] : '0;
    check_eq("count", 32'(count), sz);
    check_eq("empty", 32'(empty), 32'(sz == 0));
    check_eq("full", 32'(full), 32'(sz == DEPTH));
    check_eq("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    check_eq("out_valid", 32'(out_valid), 32'(sz != 0));
    check_eq("head", 32'({out_lr_bar, out_data}), 32'(head));
`ifdef SHIFT_CMD_FIFO_OVF_EN
    check_eq("ovf", 32'(ovf), 32'(ovf_m));
`endif
  endtask

  // One clock: check outputs on the falling edge, drive inputs, then advance the model
  // at the rising edge using the rules of the handshake.
  task automatic step(input logic r, input logic v, input logic lr,
                      input logic [DATA_W-1:0] d, input logic rdy);
    bit push, pop;
    @(negedge clk);
    check_outputs();
    rst       = r;
    in_valid  = v;
    in_lr_bar = lr;
    in_data   = d;
    out_ready = rdy;
    push = v && (model_q.size() < DEPTH);
    pop  = rdy && (model_q.size() > 0);
    @(posedge clk);
    if (r) begin
      model_q.delete();
      ovf_m = 1'b0;
    end else begin
      if (v && model_q.size() == DEPTH) ovf_m = 1'b1;
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back({lr, d});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic              rv, rl, rr, rs;

    // Reset then idle, with a command presented during reset.
    rst = 1'b1; in_valid = 1'b1; in_lr_bar = 1'b1; in_data = 4'hF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    ovf_m = 1'b0;
    idle(1);

    // Single command fall-through, then pop it.
    step(1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);

    // Fill to full with alternating direction, try a fifth push, then drain.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'(i % 2), 4'(i), 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'h5, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);

    // Hold two entries and stream ten commands through with push and pop every cycle.
    step(1'b0, 1'b1, 1'b0, 4'h6, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'h7, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'(i % 3 == 0), 4'(i + 8), 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Reset mid-operation while pushing; next command pushed must be the first out.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'(i + 2), 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'hC, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'hA, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);

    // Fill, stall one extra cycle against full, drain, then reset (exercises ovf if present).
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 4'(i + 12), 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(1);

    // Randomized traffic with occasional resets; data is undriven while in_valid is low.
    for (int i = 0; i < 600; i++) begin
      rv = 1'($urandom_range(0, 99) < 60);
      rr = 1'($urandom_range(0, 99) < 50);
      rl = 1'($urandom);
      rs = 1'($urandom_range(0, 99) < 2);
      rd = rv ? 4'($urandom) : 4'bxxxx;
      step(rs, rv, rl, rd, rr);
    end

    @(negedge clk);
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
